// File: rtl/mem_stage_pkg.sv
// mem_stage shared types: FSM state enum, default constants
// and byte-to-SRAM-word address translation.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } mem_state_t;

  localparam int unsigned DEF_ADDR_BASE   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 4;

  function automatic logic [31:0] word_addr(
    input logic [31:0] byte_addr,
    input logic [31:0] base
  );
    logic [31:0] off;
    off = byte_addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Two-phase 16-bit SRAM controller for 32-bit accesses.
// All strobes, address and data are registered.
module sram_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   wr,
  input  logic [SRAM_ADDR_W-2:0] word,
  input  logic [31:0]            wdata,
  input  logic [15:0]            dq_in,
  output logic                   ready,
  output logic [31:0]            rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            dq_out,
  output logic                   dq_oe,
  output logic                   ce_n,
  output logic                   oe_n,
  output logic                   we_n
);

  mem_state_t state;
  logic [3:0] cnt;
  logic       is_wr;
  logic       last;

  assign last  = (cnt == 4'(WAIT_CYCLES - 1));
  assign ready = (state == DONE) |
                 ((state == IDLE) & ~req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_wr     <= 1'b0;
      rdata     <= '0;
      sram_addr <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      ce_n      <= 1'b1;
      oe_n      <= 1'b1;
      we_n      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= LOW;
            cnt       <= '0;
            is_wr     <= wr;
            sram_addr <= {word, 1'b0};
            dq_out    <= wdata[15:0];
            dq_oe     <= wr;
            ce_n      <= 1'b0;
            oe_n      <= wr;
            we_n      <= 1'b1;
          end
        end
        LOW, HIGH: begin
          if (!last) begin
            cnt  <= cnt + 4'd1;
            we_n <= ~is_wr;
          end else begin
            cnt  <= '0;
            we_n <= 1'b1;
            if (!is_wr && state == LOW)
              rdata[15:0] <= dq_in;
            if (!is_wr && state == HIGH)
              rdata[31:16] <= dq_in;
            if (state == LOW) begin
              state     <= HIGH;
              sram_addr <= {word, 1'b1};
              dq_out    <= wdata[31:16];
            end else begin
              // DONE never re-arms on the stale request
              state <= DONE;
              dq_oe <= 1'b0;
              ce_n  <= 1'b1;
              oe_n  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage over external 16-bit SRAM.
// Define MEM_STAGE_LOCAL_RAM_EN for a 64x32 internal RAM instead.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DEF_ADDR_BASE,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int unsigned SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_en_in,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            val_rm,
  input  logic [3:0]             dest_in,
  output logic                   ready,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic [31:0]            alu_result_out,
  output logic [3:0]             dest_out,
  output logic [31:0]            mem_rdata,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  logic [SRAM_ADDR_W-2:0] word;

  assign word = (SRAM_ADDR_W-1)'(
    word_addr(alu_result, 32'(ADDR_BASE)));

  assign wb_en_out      = wb_en_in & ready;
  assign mem_r_en_out   = mem_r_en & ready;
  assign alu_result_out = alu_result;
  assign dest_out       = dest_in;

`ifdef MEM_STAGE_LOCAL_RAM_EN

  logic [31:0] ram [64];
  logic [5:0]  idx;
  logic        unused_ok;

  assign idx       = word[5:0];
  assign unused_ok = &{1'b0, sram_dq_in,
                       word[SRAM_ADDR_W-2:6]};

  always_ff @(posedge clk) begin
    if (mem_w_en)
      ram[idx] <= val_rm;
  end

  always_ff @(posedge clk) begin
    if (rst)
      mem_rdata <= '0;
    else if (mem_r_en && !mem_w_en)
      mem_rdata <= ram[idx];
  end

  assign ready       = 1'b1;
  assign sram_addr   = '0;
  assign sram_dq_out = '0;
  assign sram_dq_oe  = 1'b0;
  assign sram_ce_n   = 1'b1;
  assign sram_oe_n   = 1'b1;
  assign sram_we_n   = 1'b1;

`else

  sram_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .SRAM_ADDR_W (SRAM_ADDR_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .req       (mem_r_en | mem_w_en),
    .wr        (mem_w_en),
    .word      (word),
    .wdata     (val_rm),
    .dq_in     (sram_dq_in),
    .ready     (ready),
    .rdata     (mem_rdata),
    .sram_addr (sram_addr),
    .dq_out    (sram_dq_out),
    .dq_oe     (sram_dq_oe),
    .ce_n      (sram_ce_n),
    .oe_n      (sram_oe_n),
    .we_n      (sram_we_n)
  );

`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a behavioural
// 16-bit SRAM and a read-data scoreboard.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en, mem_w_en;
  logic [31:0] alu_result, val_rm;
  logic [3:0]  dest_in;
  logic        ready, wb_en_out, mem_r_en_out;
  logic [31:0] alu_result_out, mem_rdata;
  logic [3:0]  dest_out;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

  int checks = 0;
  int failures = 0;

  logic [15:0] sram [256];
  int          we_cnt [256];
  int          toggles = 0;
  logic [2:0]  prev_strb = 3'b111;
  logic [31:0] shadow [64];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .alu_result(alu_result),
    .val_rm(val_rm), .dest_in(dest_in),
    .ready(ready), .wb_en_out(wb_en_out),
    .mem_r_en_out(mem_r_en_out),
    .alu_result_out(alu_result_out),
    .dest_out(dest_out), .mem_rdata(mem_rdata),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ?
                      sram[sram_addr[7:0]] : 16'h0000;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]   = 16'h0000;
      we_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      we_cnt[sram_addr[7:0]] <= we_cnt[sram_addr[7:0]] + 1;
      if (sram_dq_oe)
        sram[sram_addr[7:0]] <= sram_dq_out;
    end
  end

  always @(negedge clk) begin
    if ({sram_ce_n, sram_oe_n, sram_we_n} != prev_strb)
      toggles <= toggles + 1;
    prev_strb <= {sram_ce_n, sram_oe_n, sram_we_n};
  end

  task automatic run_op(
    input logic r, input logic w,
    input logic [31:0] a, input logic [31:0] d,
    output int low
  );
    bit done;
    @(posedge clk); #1;
    mem_r_en = r; mem_w_en = w;
    alu_result = a; val_rm = d;
    wb_en_in = r; dest_in = 4'd5;
    if (w) shadow[(a - 1024) >> 2] = d;
    else if (r) exp_q.push_back(shadow[(a - 1024) >> 2]);
    low = 0;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (ready) done = 1;
      else begin
        low++;
        if (wb_en_out !== 1'b0 || mem_r_en_out !== 1'b0) begin
          checks++; failures++;
          $display("FAIL stall_gate wb=%b rd=%b want 0",
                   wb_en_out, mem_r_en_out);
        end
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout waiting for ready");
    end
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    mem_r_en = 0; mem_w_en = 0; wb_en_in = 0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1; mem_r_en = 0; mem_w_en = 0; wb_en_in = 0;
    alu_result = 0; val_rm = 0; dest_in = 0;
    for (int i = 0; i < 64; i++) shadow[i] = 0;
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL rst_ready got %b want 1", ready);
    end
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      failures++;
      $display("FAIL rst_strobes got %b want 111",
               {sram_ce_n, sram_oe_n, sram_we_n});
    end
    checks++;
    if (sram_dq_oe !== 1'b0 || sram_addr !== 18'd0) begin
      failures++;
      $display("FAIL rst_bus oe=%b addr=%h want 0/0",
               sram_dq_oe, sram_addr);
    end
    checks++;
    if (mem_rdata !== 32'd0) begin
      failures++; $display("FAIL rst_rdata got %h want 0", mem_rdata);
    end
  endtask

  task automatic test_store;
    int low, w2, w3;
    w2 = we_cnt[2]; w3 = we_cnt[3];
    run_op(0, 1, 1028, 32'hDEADBEEF, low);
    checks++;
    if (low !== 9) begin
      failures++; $display("FAIL store_stall got %0d want 9", low);
    end
    checks++;
    if (we_cnt[2] - w2 !== 3 || we_cnt[3] - w3 !== 3) begin
      failures++;
      $display("FAIL store_we_len got %0d/%0d want 3/3",
               we_cnt[2] - w2, we_cnt[3] - w3);
    end
    checks++;
    if (sram[2] !== 16'hBEEF || sram[3] !== 16'hDEAD) begin
      failures++;
      $display("FAIL store_data got %h/%h want BEEF/DEAD",
               sram[2], sram[3]);
    end
    checks++;
    if (mem_rdata !== 32'd0) begin
      failures++; $display("FAIL store_rdata got %h want 0", mem_rdata);
    end
    checks++;
    if (sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL store_done_bus ce_n=%b oe=%b want 1/0",
               sram_ce_n, sram_dq_oe);
    end
  endtask

  task automatic test_load;
    int low;
    logic [31:0] e;
    run_op(1, 0, 1028, 32'h0, low);
    e = exp_q.pop_front();
    checks++;
    if (low !== 9) begin
      failures++; $display("FAIL load_stall got %0d want 9", low);
    end
    checks++;
    if (mem_rdata !== e) begin
      failures++; $display("FAIL load_data got %h want %h", mem_rdata, e);
    end
    checks++;
    if (wb_en_out !== 1'b1 || mem_r_en_out !== 1'b1) begin
      failures++;
      $display("FAIL load_done_gate wb=%b rd=%b want 1/1",
               wb_en_out, mem_r_en_out);
    end
  endtask

  task automatic test_nonmem;
    int t0;
    int bad;
    go_idle(1);
    #1;
    wb_en_in = 1; alu_result = 32'h12345678; dest_in = 4'd9;
    t0 = toggles;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ready !== 1'b1 || wb_en_out !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL nonmem_ready bad_cycles=%0d want 0", bad);
    end
    checks++;
    if (alu_result_out !== 32'h12345678 || dest_out !== 4'd9) begin
      failures++;
      $display("FAIL nonmem_pass got %h/%h want 12345678/9",
               alu_result_out, dest_out);
    end
    checks++;
    if (toggles != t0 || mem_r_en_out !== 1'b0) begin
      failures++;
      $display("FAIL nonmem_strobe toggles=%0d rd=%b want 0/0",
               toggles - t0, mem_r_en_out);
    end
  endtask

  task automatic test_back_to_back;
    int l1, l2;
    logic [31:0] e;
    run_op(0, 1, 1024, 32'hCAFEF00D, l1);
    run_op(1, 0, 1024, 32'h0, l2);
    e = exp_q.pop_front();
    checks++;
    if (l1 !== 9 || l2 !== 9) begin
      failures++; $display("FAIL b2b_stall got %0d/%0d want 9/9", l1, l2);
    end
    checks++;
    if (sram[0] !== 16'hF00D || sram[1] !== 16'hCAFE) begin
      failures++;
      $display("FAIL b2b_sram got %h/%h want F00D/CAFE", sram[0], sram[1]);
    end
    checks++;
    if (mem_rdata !== e) begin
      failures++; $display("FAIL b2b_rdata got %h want %h", mem_rdata, e);
    end
  endtask

  task automatic test_both_en;
    int low;
    logic [31:0] e;
    run_op(1, 1, 1032, 32'h11112222, low);
    checks++;
    if (mem_rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL both_rdata got %h want cafef00d", mem_rdata);
    end
    checks++;
    if (sram[4] !== 16'h2222 || sram[5] !== 16'h1111 || low !== 9) begin
      failures++;
      $display("FAIL both_write got %h/%h stall %0d want 2222/1111/9",
               sram[4], sram[5], low);
    end
    checks++;
    if (mem_r_en_out !== 1'b1) begin
      failures++; $display("FAIL both_rd_gate got %b want 1", mem_r_en_out);
    end
    run_op(1, 0, 1032, 32'h0, low);
    e = exp_q.pop_front();
    checks++;
    if (mem_rdata !== e) begin
      failures++; $display("FAIL both_readback got %h want %h", mem_rdata, e);
    end
  endtask

  task automatic test_reset_mid;
    go_idle(1);
    #1;
    mem_r_en = 1; mem_w_en = 0; wb_en_in = 1; alu_result = 1028;
    repeat (7) @(posedge clk);
    #1;
    rst = 1; mem_r_en = 0; wb_en_in = 0;
    @(negedge clk);
    checks++;
    if (sram_oe_n !== 1'b0 || sram_addr !== 18'd3) begin
      failures++;
      $display("FAIL mid_active oe_n=%b addr=%h want 0/3",
               sram_oe_n, sram_addr);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if (mem_rdata !== 32'd0) begin
      failures++; $display("FAIL mid_rdata got %h want 0", mem_rdata);
    end
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 4'b1110) begin
      failures++;
      $display("FAIL mid_strobes got %b want 1110",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe});
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL mid_ready got %b want 1", ready);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_nonmem();
    test_back_to_back();
    test_both_en();
    test_reset_mid();
    go_idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
